mips_io_ctrl: RTL

Memory-mapped I/O controller between the MIPS processor's IO bus (IOAddr/IOWriteEn/IOWriteData/IOReadData) and the board peripherals. It sits directly downstream of the processor and upstream of the 7-segment display multiplexer, driving the 28-bit display pattern register. It also owns the switch path, with a 2-flop synchronizer and debouncer feeding the snake-speed input. It provides a free-running tick timer, so software can pace the animation without busy-loop calibration.

---
 rtl/mips_io_ctrl_if.sv | 10 +
 rtl/mips_io_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/mips_io_ctrl_if.sv
// rtl/mips_io_ctrl_if.sv - processor IO bus between the MIPS core and the IO controller
interface mips_io_ctrl_if;
  logic [3:0]  IOAddr;
  logic        IOWriteEn;
  logic [31:0] IOWriteData;
  logic [31:0] IOReadData;

  modport master (output IOAddr, IOWriteEn, IOWriteData, input IOReadData);
  modport slave  (input IOAddr, IOWriteEn, IOWriteData, output IOReadData);
endinterface

// File: rtl/mips_io_ctrl.sv
// rtl/mips_io_ctrl.sv - memory-mapped IO: display register, debounced switches, tick timer
module mips_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TICK_DIV        = 1000000
) (
  input  logic           CLK,
  input  logic           RESET,
  mips_io_ctrl_if.slave  bus,
  input  logic [1:0]     IN,
  output logic [27:0]    DispReg
);
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_sync2_prev;
  logic [1:0]    r_sw_stable;
  logic [DW-1:0] r_db_cnt;
  logic [PW-1:0] r_presc;
  logic          r_tick_flag;
  logic [31:0]   r_tick_count;
  logic [27:0]   r_disp;

  logic w_wrap;
  logic w_wr_disp;
  logic w_wr_clr;
  logic w_wr_count;

  assign w_wrap     = (r_presc == PW'(TICK_DIV - 1));
  assign w_wr_disp  = bus.IOWriteEn && (bus.IOAddr == 4'h0);
  assign w_wr_clr   = bus.IOWriteEn && (bus.IOAddr == 4'h8) && bus.IOWriteData[0];
  assign w_wr_count = bus.IOWriteEn && (bus.IOAddr == 4'hC);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1      <= 2'b00;
      r_sync2      <= 2'b00;
      r_sync2_prev <= 2'b00;
      r_sw_stable  <= 2'b00;
      r_db_cnt     <= '0;
      r_presc      <= '0;
      r_tick_flag  <= 1'b0;
      r_tick_count <= 32'h0;
      r_disp       <= 28'h0;
    end else begin
      r_sync1      <= IN;
      r_sync2      <= r_sync1;
      r_sync2_prev <= r_sync2;

      // Any bounce, or agreement with the accepted value, restarts the stability count.
      if ((r_sync2 == r_sw_stable) || (r_sync2 != r_sync2_prev)) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_sw_stable <= r_sync2;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end

      r_presc <= w_wrap ? '0 : r_presc + 1'b1;

      // Set beats clear so a tick landing on a clear is never lost.
      if (w_wrap) begin
        r_tick_flag <= 1'b1;
      end else if (w_wr_clr) begin
        r_tick_flag <= 1'b0;
      end

      if (w_wr_count) begin
        r_tick_count <= bus.IOWriteData;
      end else if (w_wrap) begin
        r_tick_count <= r_tick_count + 32'h1;
      end

      if (w_wr_disp) begin
        r_disp <= bus.IOWriteData[27:0];
      end
    end
  end

  always_comb begin
    bus.IOReadData = 32'h0;
    case (bus.IOAddr)
      4'h0:    bus.IOReadData = {4'b0, r_disp};
      4'h4:    bus.IOReadData = {30'b0, r_sw_stable};
      4'h8:    bus.IOReadData = {31'b0, r_tick_flag};
      4'hC:    bus.IOReadData = r_tick_count;
      default: bus.IOReadData = 32'h0;
    endcase
  end

  assign DispReg = r_disp;
endmodule
